// File: rtl/md_operand_sequencer_if.sv
// Handshake/data bundle between the multiply/divide sequencer and the
// digit-serial operand/quotient register.
interface md_operand_sequencer_if #(
    parameter int WORD  = 26,
    parameter int DIGIT = 2
);
    logic             start;
    logic             mode;
    logic [WORD-1:0]  operand;
    logic             step;
    logic [DIGIT-1:0] qdig;
    logic [5:0]       md;
    logic             busy;
    logic             done;
    logic [WORD-1:0]  result;
    logic [3:0]       steps_left;
    logic             step_err;

    modport master (
        output start, mode, operand, step, qdig,
        input  md, busy, done, result, steps_left, step_err
    );

    modport slave (
        input  start, mode, operand, step, qdig,
        output md, busy, done, result, steps_left, step_err
    );
endinterface

// File: rtl/md_operand_sequencer.sv
// Digit-serial operand shifter and quotient assembler for the multiply/divide
// datapath: retires DIGIT bits per STEP and exposes a 6-bit operand window.
module md_operand_sequencer #(
    parameter int WORD  = 26,
    parameter int DIGIT = 2,
    parameter int STEPS = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    md_operand_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [WORD-1:0] sr_r;
    logic [WORD-1:0] sr_nxt_s;
    logic [WORD-1:0] qr_r;
    logic [WORD-1:0] qr_nxt_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_nxt_s;
    logic            mode_r;
    logic            mode_nxt_s;
    logic            step_err_r;
    logic            step_err_nxt_s;
    logic [WORD-1:0] result_r;
    logic [WORD-1:0] result_nxt_s;

    logic [5:0]      md_r;
    logic            busy_r;
    logic            done_r;
    logic [3:0]      steps_left_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath next values; everything holds unless updated
    always_comb begin
        state_nxt_s    = state_r;
        sr_nxt_s       = sr_r;
        qr_nxt_s       = qr_r;
        cnt_nxt_s      = cnt_r;
        mode_nxt_s     = mode_r;
        step_err_nxt_s = step_err_r;
        result_nxt_s   = result_r;

        case (state_r)
            IDLE: begin
                // START wins over a coincident STEP, which is then neither
                // applied nor flagged.
                if (bus.start) begin
                    sr_nxt_s       = bus.operand;
                    qr_nxt_s       = {WORD{1'b0}};
                    cnt_nxt_s      = 4'(STEPS);
                    mode_nxt_s     = bus.mode;
                    step_err_nxt_s = 1'b0;
                    state_nxt_s    = RUN;
                end else if (bus.step) begin
                    step_err_nxt_s = 1'b1;
                end else begin
                    step_err_nxt_s = step_err_r;
                end
            end

            RUN: begin
                if (bus.step) begin
                    if (mode_r) begin
                        sr_nxt_s = sr_r >> DIGIT;
                        qr_nxt_s = {qr_r[WORD-DIGIT-1:0], bus.qdig};
                    end else begin
                        sr_nxt_s = WORD'($signed(sr_r) >>> DIGIT);
                        qr_nxt_s = qr_r;
                    end
                    cnt_nxt_s = cnt_r - 4'd1;
                    // RESULT captures the quotient including the final digit
                    if (cnt_r == 4'd1) begin
                        state_nxt_s  = FIN;
                        result_nxt_s = mode_r ? qr_nxt_s : {WORD{1'b0}};
                    end else begin
                        state_nxt_s  = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end

            FIN: begin
                state_nxt_s = IDLE;
                if (bus.step) begin
                    step_err_nxt_s = 1'b1;
                end else begin
                    step_err_nxt_s = step_err_r;
                end
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r       <= {WORD{1'b0}};
            qr_r       <= {WORD{1'b0}};
            cnt_r      <= 4'd0;
            mode_r     <= 1'b0;
            step_err_r <= 1'b0;
            result_r   <= {WORD{1'b0}};
        end else begin
            sr_r       <= sr_nxt_s;
            qr_r       <= qr_nxt_s;
            cnt_r      <= cnt_nxt_s;
            mode_r     <= mode_nxt_s;
            step_err_r <= step_err_nxt_s;
            result_r   <= result_nxt_s;
        end
    end

    // Status outputs registered from next-state values so they align with state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_r         <= 6'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            steps_left_r <= 4'd0;
        end else begin
            md_r         <= (state_nxt_s == RUN) ? sr_nxt_s[5:0] : 6'd0;
            busy_r       <= (state_nxt_s == RUN);
            done_r       <= (state_nxt_s == FIN);
            steps_left_r <= (state_nxt_s == RUN) ? cnt_nxt_s : 4'd0;
        end
    end

    assign bus.md         = md_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.result     = result_r;
    assign bus.steps_left = steps_left_r;
    assign bus.step_err   = step_err_r;

endmodule

// File: tb/tb_md_operand_sequencer.sv
// Randomized bench for md_operand_sequencer against a behavioural operation model.
module tb_md_operand_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_operand_sequencer_if bus ();

    md_operand_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: steps remaining, FIN pulse pending, operand, quotient
    int          m_left;
    bit          m_fin;
    bit          m_div;
    bit          m_err;
    logic [25:0] m_sr;
    logic [25:0] m_q;
    logic [25:0] m_res;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_left = 0; m_fin = 1'b0; m_div = 1'b0; m_err = 1'b0;
        m_sr = 26'd0; m_q = 26'd0; m_res = 26'd0;
    endtask

    task automatic model_edge(input bit start, input bit mode, input logic [25:0] operand,
                              input bit step, input logic [1:0] qdig);
        if (m_fin) begin
            m_fin = 1'b0;
            if (step) m_err = 1'b1;
        end else if (m_left > 0) begin
            if (step) begin
                if (m_div) begin
                    m_sr = m_sr / 26'd4;
                    m_q  = m_q * 26'd4 + {24'd0, qdig};
                end else begin
                    m_sr = 26'($signed(m_sr) >>> 2);
                end
                m_left--;
                if (m_left == 0) begin
                    m_fin = 1'b1;
                    m_res = m_div ? m_q : 26'd0;
                end
            end
        end else if (start) begin
            m_sr = operand; m_q = 26'd0; m_left = 13; m_div = mode; m_err = 1'b0;
        end else if (step) begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_outputs();
        bit b;
        b = (m_left > 0) && !m_fin;
        check("busy",       {31'd0, bus.busy},     {31'd0, b});
        check("done",       {31'd0, bus.done},     {31'd0, m_fin});
        check("md",         {26'd0, bus.md},       b ? {26'd0, m_sr[5:0]} : 32'd0);
        check("steps_left", {28'd0, bus.steps_left}, b ? m_left : 32'd0);
        check("result",     {6'd0, bus.result},    {6'd0, m_res});
        check("step_err",   {31'd0, bus.step_err}, {31'd0, m_err});
    endtask

    task automatic cyc(input bit start, input bit mode, input logic [25:0] operand,
                       input bit step, input logic [1:0] qdig);
        @(negedge clk);
        bus.start = start; bus.mode = mode; bus.operand = operand;
        bus.step = step;   bus.qdig = qdig;
        @(posedge clk);
        model_edge(start, mode, operand, step, qdig);
        #1;
        check_outputs();
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'($urandom), 26'($urandom), 1'b0, 2'($urandom));
    endtask

    task automatic start_op(input bit mode, input logic [25:0] operand, input bit with_step);
        cyc(1'b1, mode, operand, with_step, 2'($urandom));
    endtask

    // qsel: 0 -> digit 01, 1 -> alternating 10/11 starting with 10, 2 -> random
    task automatic steps(input int n, input int gap_max, input int qsel, input int inj_start_at);
        logic [1:0] d;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) idle_cyc();
            if (i == inj_start_at)
                cyc(1'b1, 1'($urandom), 26'($urandom), 1'b0, 2'($urandom));
            case (qsel)
                0:       d = 2'b01;
                1:       d = (i % 2 == 0) ? 2'b10 : 2'b11;
                default: d = 2'($urandom);
            endcase
            cyc(1'b0, 1'($urandom), 26'($urandom), 1'b1, d);
        end
    endtask

    task automatic do_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        bus.start = 1'b0; bus.step = 1'b0;
        rst = 1'b0;
    endtask

    logic [25:0] exp_alt;

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.operand = 26'd0;
        bus.step = 1'b0;  bus.qdig = 2'd0;
        rst = 1'b1;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Multiply with sign fill, back-to-back steps
        start_op(1'b0, 26'h2AAAAAA, 1'b0);
        check("mul_md_load", {26'd0, bus.md}, 32'h2A);
        steps(13, 0, 2, -1);
        check("mul_done", {31'd0, bus.done}, 32'd1);
        check("mul_result", {6'd0, bus.result}, 32'd0);
        idle_cyc();

        // Divide 0x3F with digit 01 on every step
        start_op(1'b1, 26'h000003F, 1'b0);
        steps(13, 0, 0, -1);
        check("div_result", {6'd0, bus.result}, 32'h1555555);
        idle_cyc();

        // Gapped divide, alternating digits
        exp_alt = 26'd0;
        for (int i = 0; i < 13; i++) exp_alt = exp_alt * 26'd4 + ((i % 2 == 0) ? 26'd2 : 26'd3);
        start_op(1'b1, 26'($urandom), 1'b0);
        steps(13, 3, 1, -1);
        check("gap_result", {6'd0, bus.result}, {6'd0, exp_alt});
        cyc(1'b1, 1'b0, 26'($urandom), 1'b1, 2'd0);   // START and STEP in FIN
        check("fin_step_err", {31'd0, bus.step_err}, 32'd1);

        // Protocol errors
        cyc(1'b0, 1'b0, 26'd0, 1'b1, 2'd3);
        check("idle_step_err", {31'd0, bus.step_err}, 32'd1);
        start_op(1'b1, 26'($urandom), 1'b1);
        check("start_step_err", {31'd0, bus.step_err}, 32'd0);
        check("start_step_left", {28'd0, bus.steps_left}, 32'd13);
        steps(13, 1, 2, 5);
        idle_cyc();

        // Async reset mid-operation, then a full operation
        start_op(1'b1, 26'($urandom), 1'b0);
        steps(6, 1, 2, -1);
        do_async_reset();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        start_op(1'b0, 26'($urandom), 1'b0);
        steps(13, 2, 2, -1);
        idle_cyc();

        // RESULT held across a following multiply until its FIN
        start_op(1'b1, 26'h000003F, 1'b0);
        steps(13, 0, 0, -1);
        idle_cyc();
        start_op(1'b0, 26'($urandom), 1'b0);
        check("hold_after_start", {6'd0, bus.result}, 32'h1555555);
        steps(12, 1, 2, -1);
        check("hold_before_fin", {6'd0, bus.result}, 32'h1555555);
        steps(1, 0, 2, -1);
        check("hold_cleared", {6'd0, bus.result}, 32'd0);
        idle_cyc();

        // Random operations with stray STEP/START traffic
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b0, 26'($urandom), 1'b1, 2'($urandom));
            start_op(1'($urandom), 26'($urandom), 1'($urandom));
            steps(13, 3, 2, int'($urandom_range(0, 15)));
            cyc(1'b0, 1'b0, 26'($urandom), 1'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 2)) idle_cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
